// File: rtl/flash_ctrl.sv
// flash_ctrl: single-beat request/response initiator for a parallel flash device.
// Writes become a WR_CYCLES-long cs_n/we_n pulse; reads assert cs_n/oe_n and wait
// for a qualified ready, with a TIMEOUT-cycle error path.
// Optional feature macro: FLASH_CTRL_WRITE_VERIFY_EN -- every write is followed by a
// readback of the same address; the response carries the readback and flags a mismatch.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready; a
// response transfers on a rising edge where rsp_valid && rsp_ready. rsp_valid and its
// payload stay stable until that transfer, and req_ready is high only in IDLE.
module flash_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int WR_CYCLES = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cs_n,
  output logic              we_n,
  output logic              oe_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready
);

  localparam int WC_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int TW   = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
`ifdef FLASH_CTRL_WRITE_VERIFY_EN
    S_VGAP,
`endif
    S_RESP
  } state_t;

  // state_q is the FSM state, visible hierarchically for checkers
  state_t state_q, state_d;

  logic [WC_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              cs_n_d, we_n_d, oe_n_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rsp_rdata_d;

  logic accept, wr_done, rd_hit, rd_to;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign wr_done   = (state_q == S_WRITE) && (wr_cnt_q == WC_W'(WR_CYCLES - 1));
  // wait_cnt==0 is the first READ cycle: a ready seen then belongs to an earlier access
  assign rd_hit    = (state_q == S_READ) && (wait_cnt_q != '0) && ready;
  assign rd_to     = (state_q == S_READ) && !rd_hit && (wait_cnt_q == TW'(TIMEOUT - 1));

`ifdef FLASH_CTRL_WRITE_VERIFY_EN
  // Marks that the current READ is the readback of a write
  logic verify_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           verify_q <= 1'b0;
    else if (accept)                      verify_q <= 1'b0;
    else if (state_q == S_VGAP)           verify_q <= 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = req_we ? S_WRITE : S_READ;
`ifdef FLASH_CTRL_WRITE_VERIFY_EN
      S_WRITE: if (wr_done) state_d = S_VGAP;
      S_VGAP:  state_d = S_READ;
`else
      S_WRITE: if (wr_done) state_d = S_RESP;
`endif
      S_READ:  if (rd_hit || rd_to) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered flash-side and response outputs
  always_comb begin
    cs_n_d      = cs_n;
    we_n_d      = we_n;
    oe_n_d      = oe_n;
    addr_d      = addr;
    wdata_d     = wdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    wr_cnt_d    = wr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cs_n_d  = 1'b0;
          if (req_we) begin
            we_n_d   = 1'b0;
            wr_cnt_d = '0;
          end else begin
            oe_n_d     = 1'b0;
            wait_cnt_d = '0;
          end
        end
      end
      S_WRITE: begin
        if (wr_done) begin
          cs_n_d = 1'b1;
          we_n_d = 1'b1;
`ifndef FLASH_CTRL_WRITE_VERIFY_EN
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
`endif
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
`ifdef FLASH_CTRL_WRITE_VERIFY_EN
      // One idle strobe cycle between the write pulse and the readback
      S_VGAP: begin
        cs_n_d     = 1'b0;
        oe_n_d     = 1'b0;
        wait_cnt_d = '0;
      end
`endif
      S_READ: begin
        if (wait_cnt_q != TW'(TIMEOUT - 1)) wait_cnt_d = wait_cnt_q + 1'b1;
        if (rd_hit) begin
          rsp_rdata_d = rdata;
`ifdef FLASH_CTRL_WRITE_VERIFY_EN
          rsp_err_d   = verify_q && (rdata != wdata);
`else
          rsp_err_d   = 1'b0;
`endif
          rsp_valid_d = 1'b1;
          cs_n_d      = 1'b1;
          oe_n_d      = 1'b1;
        end else if (rd_to) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cs_n_d      = 1'b1;
          oe_n_d      = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n       <= 1'b1;
      we_n       <= 1'b1;
      oe_n       <= 1'b1;
      addr       <= '0;
      wdata      <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      wr_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      cs_n       <= cs_n_d;
      we_n       <= we_n_d;
      oe_n       <= oe_n_d;
      addr       <= addr_d;
      wdata      <= wdata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      wr_cnt_q   <= wr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: flash_ctrl against a small behavioural flash device model.
// The device answers reads with ready one cycle after cs_n/oe_n are seen low and keeps
// ready asserted for a few cycles after release, so stale-ready rejection is exercised.
module tb_flash_ctrl;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 32;
  localparam int WR_CYCLES = 1;
  localparam int TIMEOUT   = 15;
`ifdef FLASH_CTRL_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int RD_LAT    = 3;
  localparam int TO_LAT    = TIMEOUT + 1;
  localparam int WR_LAT    = VERIFY ? (WR_CYCLES + 1 + RD_LAT) : (WR_CYCLES + 1);
  localparam int WR_TO_LAT = VERIFY ? (WR_CYCLES + 1 + TO_LAT) : (WR_CYCLES + 1);

  logic              clk, rst_n;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr, addr;
  logic [DATA_W-1:0] req_wdata, wdata, rdata, rsp_rdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic              cs_n, we_n, oe_n, ready;

  int errors = 0;
  int checks = 0;

  flash_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs_n(cs_n), .we_n(we_n), .oe_n(oe_n), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- flash device model ----------------
  logic [31:0] stub_mem [0:255];
  logic [1:0]  tail;
  bit          force_nr = 1'b0;
  bit          block_wr = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) stub_mem[i] = '0;
    ready = 1'b0;
    rdata = '0;
    tail  = '0;
  end

  always @(posedge clk) begin
    if (!cs_n && !we_n && !block_wr) stub_mem[addr[7:0]] <= wdata;
    if (!cs_n && !oe_n) begin
      ready <= !force_nr;
      rdata <= stub_mem[addr[7:0]];
      tail  <= 2'd3;
    end else if (tail != 2'd0) begin
      ready <= !force_nr;
      tail  <= tail - 2'd1;
    end else begin
      ready <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash-side rules: we_n/oe_n never both low, addr stable while cs_n low
  bit          mon_en = 1'b0;
  logic        prev_cs_low = 1'b0;
  logic [23:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mon_en && rst_n && !cs_n) begin
      check("we_oe_exclusive", {63'd0, (!we_n && !oe_n)}, 64'd0);
      if (prev_cs_low) check("addr_stable", {40'd0, addr}, {40'd0, prev_addr});
    end
    prev_cs_low = rst_n && !cs_n;
    prev_addr   = addr;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] exp_mem [int];
  logic [32:0] exp_q [$];

  function automatic logic [31:0] mem_rd(input int a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'd0;
  endfunction

  // Expected {err, rdata} and latency for a transaction, from the interface rules
  task automatic predict(input logic we, input int a, input logic [31:0] d, input bit fnr,
                         output logic [32:0] er, output int lat);
    if (we) begin
      if (!VERIFY)  begin er = {1'b0, 32'd0}; lat = WR_LAT; end
      else if (fnr) begin er = {1'b1, 32'd0}; lat = WR_TO_LAT; end
      else          begin er = {1'b0, d};     lat = WR_LAT; end
      exp_mem[a] = d;
    end else begin
      if (fnr) begin er = {1'b1, 32'd0};    lat = TO_LAT; end
      else     begin er = {1'b0, mem_rd(a)}; lat = RD_LAT; end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the response handshake.
  task automatic do_txn(input logic we, input logic [23:0] a, input logic [31:0] d,
                        input int hold, input bit fnr,
                        output logic [31:0] rd, output logic er, output int lat, output int wlow);
    int cyc;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    force_nr = fnr; rsp_ready = 1'b0;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; wlow = 0;
    while (!rsp_valid && lat < 60) begin
      if (!we_n) begin
        wlow++;
        check("write_addr", {40'd0, addr}, {40'd0, a});
        check("write_data", {32'd0, wdata}, {32'd0, d});
      end
      check("req_ready_busy", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    rd = rsp_rdata; er = rsp_err;
    check("strobes_high_at_rsp", {61'd0, cs_n, we_n, oe_n}, 64'd7);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, rd});
      check("hold_rsp_err", {63'd0, rsp_err}, {63'd0, er});
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      check("hold_strobes", {61'd0, cs_n, we_n, oe_n}, 64'd7);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    force_nr = 1'b0;
    check("rsp_cleared", {63'd0, rsp_valid}, 64'd0);
    check("back_to_idle", {63'd0, req_ready}, 64'd1);
  endtask

  // Runs one transaction and compares against the popped scoreboard entry
  task automatic run_and_score(input string tag, input logic we, input logic [23:0] a,
                               input logic [31:0] d, input int hold, input bit fnr,
                               input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat, wlow;
    logic [32:0] exp;
    do_txn(we, a, d, hold, fnr, rd, er, lat, wlow);
    exp = exp_q.pop_front();
    check({tag, "_rdata"}, {32'd0, rd}, {32'd0, exp[31:0]});
    check({tag, "_err"}, {63'd0, er}, {63'd0, exp[32]});
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_we_low_cycles"}, 64'(wlow), we ? 64'(WR_CYCLES) : 64'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          hold;
    bit          fnr;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [32:0] er;
    int          lat;
    logic [31:0] wr_echo0, wr_echo1;

    wr_echo0 = VERIFY ? 32'hDEADBEEF : 32'd0;
    wr_echo1 = VERIFY ? 32'h12345678 : 32'd0;
    vecs[0] = '{1'b1, 24'h000005, 32'hDEADBEEF, 0, 1'b0, wr_echo0,     1'b0, WR_LAT};
    vecs[1] = '{1'b0, 24'h000005, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, RD_LAT};
    vecs[2] = '{1'b1, 24'h000006, 32'h12345678, 0, 1'b0, wr_echo1,     1'b0, WR_LAT};
    vecs[3] = '{1'b0, 24'h000005, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, RD_LAT};
    vecs[4] = '{1'b0, 24'h000006, 32'h0,        0, 1'b0, 32'h12345678, 1'b0, RD_LAT};
    vecs[5] = '{1'b0, 24'h000006, 32'h0,        0, 1'b1, 32'h0,        1'b1, TO_LAT};
    vecs[6] = '{1'b0, 24'h000005, 32'h0,        5, 1'b0, 32'hDEADBEEF, 1'b0, RD_LAT};
    vecs[7] = '{1'b0, 24'h000020, 32'h0,        2, 1'b0, 32'h0,        1'b0, RD_LAT};

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_strobes", {61'd0, cs_n, we_n, oe_n}, 64'd7);
    check("reset_addr", {40'd0, addr}, 64'd0);
    check("reset_wdata", {32'd0, wdata}, 64'd0);
    check("reset_rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Table: vecs 3 and 4 run back to back, so the device's trailing ready from the
    // first read is present during the second read's first cycle.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rd});
      if (vecs[i].we) exp_mem[int'(vecs[i].addr)] = vecs[i].wdata;
      run_and_score($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].hold, vecs[i].fnr, vecs[i].exp_lat);
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      logic        we;
      int          a, hold;
      logic [31:0] d;
      bit          fnr;
      we   = 1'($urandom_range(0, 1));
      a    = $urandom_range(0, 15);
      d    = $urandom;
      hold = $urandom_range(0, 3);
      fnr  = ($urandom_range(0, 7) == 0);
      predict(we, a, d, fnr, er, lat);
      exp_q.push_back(er);
      run_and_score($sformatf("rnd%0d", n), we, 24'(a), d, hold, fnr, lat);
    end

    // Async reset while a read has the strobes asserted
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000005;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_cs_low", {63'd0, cs_n}, 64'd0);
    check("rst_mid_oe_low", {63'd0, oe_n}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {61'd0, cs_n, we_n, oe_n}, 64'd7);
    check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_mid_addr", {40'd0, addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst_no_response", {63'd0, rsp_valid}, 64'd0);
      check("rst_idle_ready", {63'd0, req_ready}, 64'd1);
    end

    predict(1'b0, 6, 32'd0, 1'b0, er, lat);
    exp_q.push_back(er);
    run_and_score("post_reset_read", 1'b0, 24'h000006, 32'd0, 1, 1'b0, lat);

    if (VERIFY) begin
      // Device ignores the write, so the readback disagrees with the written data
      block_wr = 1'b1;
      exp_q.push_back({1'b1, mem_rd(5)});
      run_and_score("verify_mismatch", 1'b1, 24'h000005, ~mem_rd(5), 0, 1'b0, WR_LAT);
      block_wr = 1'b0;
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
